// File: rtl/riscv_mdu.sv
// RV32M multiply/divide unit: single-cycle multiplier and a restoring radix-2
// divider, both sequenced by a four-state IDLE/MUL/DIV/DONE controller.
module riscv_mdu #(
    parameter int WIDTH  = 32,
    parameter int EN_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             kill_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               w_accept;
    logic               w_fast;
    logic               w_div_start;
    logic               w_div_last;
    logic [WIDTH-1:0]   w_fast_res;
    logic [WIDTH-1:0]   w_div_res;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;

    // Divide-by-zero and disabled-divider ops share the one-cycle MUL path.
    assign w_accept    = (r_state == S_IDLE) && enable_i && !kill_i;
    assign w_fast      = !op_i[2] || (EN_DIV == 0) || (operand_b_i == {WIDTH{1'b0}});
    assign w_div_start = w_accept && !w_fast;

    assign w_a_ext = {{WIDTH{((r_op == 3'b001) || (r_op == 3'b010)) && r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{(r_op == 3'b001) && r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; kill_i wins over everything, including a new request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_fast ? S_MUL : S_DIV;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MUL: begin
                if (kill_i) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DIV: begin
                if (kill_i) begin
                    w_next = S_IDLE;
                end else if (w_div_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DIV;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 3'b000;
            r_a  <= {WIDTH{1'b0}};
            r_b  <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_op <= op_i;
            r_a  <= operand_a_i;
            r_b  <= operand_b_i;
        end
    end

    // One-cycle result: product half, or the fixed divide-by-zero answers.
    always_comb begin
        w_fast_res = {WIDTH{1'b0}};
        if (!r_op[2]) begin
            if (r_op[1:0] == 2'b00) begin
                w_fast_res = w_prod[WIDTH-1:0];
            end else begin
                w_fast_res = w_prod[2*WIDTH-1:WIDTH];
            end
        end else if (EN_DIV == 0) begin
            w_fast_res = {WIDTH{1'b0}};
        end else if (r_op[1]) begin
            w_fast_res = r_a;
        end else begin
            w_fast_res = {WIDTH{1'b1}};
        end
    end

    // Result register; holds across idle and killed operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {WIDTH{1'b0}};
        end else if ((r_state == S_MUL) && !kill_i) begin
            r_result <= w_fast_res;
        end else if ((r_state == S_DIV) && !kill_i && w_div_last) begin
            r_result <= w_div_res;
        end
    end

    generate
        if (EN_DIV != 0) begin : g_div
            logic [CW-1:0]    r_cnt;
            logic             r_last;
            logic             r_neg_q;
            logic             r_neg_r;
            logic [WIDTH-1:0] r_quo;
            logic [WIDTH-1:0] r_rem;
            logic [WIDTH-1:0] r_dvs;
            logic             w_a_neg;
            logic             w_b_neg;
            logic [WIDTH-1:0] w_a_mag;
            logic [WIDTH-1:0] w_b_mag;
            logic [WIDTH:0]   w_sh;
            logic [WIDTH:0]   w_diff;

            assign w_a_neg = !op_i[0] && operand_a_i[WIDTH-1];
            assign w_b_neg = !op_i[0] && operand_b_i[WIDTH-1];
            assign w_a_mag = w_a_neg ? ({WIDTH{1'b0}} - operand_a_i) : operand_a_i;
            assign w_b_mag = w_b_neg ? ({WIDTH{1'b0}} - operand_b_i) : operand_b_i;
            assign w_sh    = {r_rem, r_quo[WIDTH-1]};
            assign w_diff  = w_sh - {1'b0, r_dvs};

            // Iterations run while r_last is clear; the edge after the last one applies signs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= {CW{1'b0}};
                    r_last  <= 1'b0;
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                    r_quo   <= {WIDTH{1'b0}};
                    r_rem   <= {WIDTH{1'b0}};
                    r_dvs   <= {WIDTH{1'b0}};
                end else if (w_div_start) begin
                    r_cnt   <= CW'(WIDTH - 1);
                    r_last  <= 1'b0;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_quo   <= w_a_mag;
                    r_rem   <= {WIDTH{1'b0}};
                    r_dvs   <= w_b_mag;
                end else if (r_state == S_DIV) begin
                    r_cnt <= r_cnt - CW'(1);
                    if (!r_last) begin
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_sh[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_last <= (r_cnt == {CW{1'b0}});
                    end
                end
            end

            assign w_div_last = r_last;
            assign w_div_res  = r_op[1] ? (r_neg_r ? ({WIDTH{1'b0}} - r_rem) : r_rem)
                                        : (r_neg_q ? ({WIDTH{1'b0}} - r_quo) : r_quo);
        end else begin : g_no_div
            assign w_div_last = 1'b0;
            assign w_div_res  = {WIDTH{1'b0}};
        end
    endgenerate

    assign ready_o  = (r_state == S_IDLE);
    assign valid_o  = (r_state == S_DONE);
    assign result_o = r_result;

endmodule

// File: tb/tb_riscv_mdu.sv
// Self-checking bench for riscv_mdu (WIDTH=32): directed literal cases plus
// randomized traffic compared cycle by cycle against an arithmetic model.
module tb_riscv_mdu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [2:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        kill_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    logic        m_ready;
    logic        m_valid;
    logic [31:0] m_result;
    logic [31:0] m_pend;
    int          m_left;

    riscv_mdu #(.WIDTH(32), .EN_DIV(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .kill_i      (kill_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] p;
        int          ix;
        int          iy;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        ix = $signed(x);
        iy = $signed(y);
        r  = 32'd0;
        case (op)
            3'd0: begin p = ux * uy; r = p[31:0];  end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = ix / iy;
            end
            3'd5: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else r = x / y;
            end
            3'd6: begin
                if (y == 32'd0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = ix % iy;
            end
            default: begin
                if (y == 32'd0) r = x;
                else r = x % y;
            end
        endcase
        return r;
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [31:0] y);
        return (op[2] && (y != 32'd0)) ? 33 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: busy countdown per accepted request, kill and reset abort.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready  <= 1'b1;
            m_valid  <= 1'b0;
            m_result <= 32'd0;
            m_pend   <= 32'd0;
            m_left   <= 0;
        end else if (m_valid) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end else if (m_ready) begin
            if (enable_i && !kill_i) begin
                m_ready <= 1'b0;
                m_left  <= lat(op_i, operand_b_i);
                m_pend  <= ref_op(op_i, operand_a_i, operand_b_i);
            end
        end else if (kill_i) begin
            m_ready <= 1'b1;
            m_left  <= 0;
        end else if (m_left == 1) begin
            m_valid  <= 1'b1;
            m_result <= m_pend;
            m_left   <= 0;
        end else begin
            m_left <= m_left - 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ready_o", 32'(ready_o), 32'(m_ready));
            check("valid_o", 32'(valid_o), 32'(m_valid));
            check("result_o", result_o, m_result);
        end
    end

    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (!ready_o && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (!ready_o) check({name, "_ready_timeout"}, 32'(ready_o), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
        int k;
        bit seen;
        wait_ready(name);
        @(posedge clk); #1;
        enable_i = 1'b1; op_i = op; operand_a_i = x; operand_b_i = y;
        @(posedge clk); #1;
        enable_i = 1'b0; operand_a_i = $urandom; operand_b_i = $urandom;
        k = 0;
        seen = 1'b0;
        while (!seen && k <= 60) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
            else k++;
        end
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        check({name, "_result"}, result_o, exp_res);
        @(negedge clk);
        check({name, "_pulse"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        int mode;
        rst_n = 1'b0; enable_i = 1'b0; kill_i = 1'b0; op_i = 3'd0;
        operand_a_i = 32'd0; operand_b_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_on = 1'b1;

        run_op("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("divu0",  3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("rem0",   3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("remu",   3'd7, 32'd1000, 32'd7, 32'd6, 33);

        // Kill a DIV at E10, then a MUL must go straight through.
        wait_ready("kill");
        @(posedge clk); #1;
        enable_i = 1'b1; op_i = 3'd4; operand_a_i = 32'd100; operand_b_i = 32'd7;
        @(posedge clk); #1;
        enable_i = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            kill_i = (k == 9);
        end
        @(negedge clk);
        check("kill_ready", 32'(ready_o), 32'd1);
        check("kill_valid", 32'(valid_o), 32'd0);
        repeat (30) @(posedge clk);
        run_op("mul_after_kill", 3'd0, 32'd3, 32'd4, 32'h0000_000C, 1);

        // Randomized traffic including kills, enable+kill in IDLE and a mid-run reset.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            mode = $urandom_range(0, 7);
            enable_i = ($urandom_range(0, 3) != 0);
            kill_i   = ($urandom_range(0, 49) == 0);
            op_i     = 3'($urandom_range(0, 7));
            case (mode)
                0: begin operand_a_i = $urandom; operand_b_i = 32'd0; end
                1: begin operand_a_i = 32'h8000_0000; operand_b_i = 32'hFFFF_FFFF; end
                2: begin operand_a_i = 32'($urandom_range(0, 40)) - 32'd20;
                         operand_b_i = 32'($urandom_range(0, 10)) - 32'd5; end
                default: begin operand_a_i = $urandom; operand_b_i = $urandom; end
            endcase
            if (i == 2000) rst_n = 1'b0;
            if (i == 2003) rst_n = 1'b1;
        end
        @(posedge clk); #1;
        enable_i = 1'b0; kill_i = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
